// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers issued ALU ops until operands resolve, then
// executes one per cycle through a calc stage into a held output register.
module alu_reservation_station #(
   parameter int RS_WIDTH    = 4,
   parameter int ROB_WIDTH   = 4,
   parameter int RS_OP_WIDTH = 4,
   parameter int FULL_MARGIN = 2
) (
   input  logic                   clockIn,
   input  logic                   resetIn,
   input  logic                   flush,
   input  logic                   addValid,
   input  logic [RS_OP_WIDTH-1:0] addOp,
   input  logic [ROB_WIDTH-1:0]   addRobIndex,
   input  logic [31:0]            addVal1,
   input  logic [31:0]            addVal2,
   input  logic                   addHasDep1,
   input  logic                   addHasDep2,
   input  logic [ROB_WIDTH-1:0]   addConstrt1,
   input  logic [ROB_WIDTH-1:0]   addConstrt2,
   output logic                   full,
   input  logic                   lsbUpdate,
   input  logic [ROB_WIDTH-1:0]   lsbRobIndex,
   input  logic [31:0]            lsbUpdateVal,
   output logic                   update,
   input  logic                   updateReady,
   output logic [ROB_WIDTH-1:0]   updateRobId,
   output logic [31:0]            updateVal
);

   localparam int DEPTH = 1 << RS_WIDTH;
   localparam logic [RS_WIDTH:0] DEPTH_COUNT = (RS_WIDTH + 1)'(DEPTH);
   localparam logic [RS_WIDTH:0] FULL_LIMIT  = (RS_WIDTH + 1)'(DEPTH - FULL_MARGIN);

   localparam logic [RS_OP_WIDTH-1:0] OP_ADD = RS_OP_WIDTH'(32'd0);
   localparam logic [RS_OP_WIDTH-1:0] OP_SUB = RS_OP_WIDTH'(32'd1);
   localparam logic [RS_OP_WIDTH-1:0] OP_XOR = RS_OP_WIDTH'(32'd2);
   localparam logic [RS_OP_WIDTH-1:0] OP_OR  = RS_OP_WIDTH'(32'd3);
   localparam logic [RS_OP_WIDTH-1:0] OP_AND = RS_OP_WIDTH'(32'd4);
   localparam logic [RS_OP_WIDTH-1:0] OP_SLL = RS_OP_WIDTH'(32'd5);
   localparam logic [RS_OP_WIDTH-1:0] OP_SRL = RS_OP_WIDTH'(32'd6);
   localparam logic [RS_OP_WIDTH-1:0] OP_SRA = RS_OP_WIDTH'(32'd7);
   localparam logic [RS_OP_WIDTH-1:0] OP_EQ  = RS_OP_WIDTH'(32'd8);
   localparam logic [RS_OP_WIDTH-1:0] OP_NE  = RS_OP_WIDTH'(32'd9);
   localparam logic [RS_OP_WIDTH-1:0] OP_LT  = RS_OP_WIDTH'(32'd10);
   localparam logic [RS_OP_WIDTH-1:0] OP_LTU = RS_OP_WIDTH'(32'd11);

   // Shift amounts use only the low five bits; compares return 0/1; unused opcodes give 0.
   function automatic logic [31:0] aluCompute(
      input logic [RS_OP_WIDTH-1:0] op,
      input logic [31:0]            a,
      input logic [31:0]            b
   );
      logic [31:0] res;
      case (op)
         OP_ADD:  res = a + b;
         OP_SUB:  res = a - b;
         OP_XOR:  res = a ^ b;
         OP_OR:   res = a | b;
         OP_AND:  res = a & b;
         OP_SLL:  res = a << b[4:0];
         OP_SRL:  res = a >> b[4:0];
         OP_SRA:  res = $unsigned($signed(a) >>> b[4:0]);
         OP_EQ:   res = {31'd0, (a == b)};
         OP_NE:   res = {31'd0, (a != b)};
         OP_LT:   res = {31'd0, ($signed(a) < $signed(b))};
         OP_LTU:  res = {31'd0, (a < b)};
         default: res = 32'd0;
      endcase
      return res;
   endfunction

   logic [DEPTH-1:0]       entryValid;
   logic [RS_OP_WIDTH-1:0] entryOp    [DEPTH];
   logic [ROB_WIDTH-1:0]   entryTag   [DEPTH];
   logic [31:0]            entryVal1  [DEPTH];
   logic [31:0]            entryVal2  [DEPTH];
   logic                   entryDep1  [DEPTH];
   logic                   entryDep2  [DEPTH];
   logic [ROB_WIDTH-1:0]   entryCons1 [DEPTH];
   logic [ROB_WIDTH-1:0]   entryCons2 [DEPTH];
   logic [RS_WIDTH:0]      count;

   logic                   calcValid;
   logic [RS_OP_WIDTH-1:0] calcOp;
   logic [31:0]            calcV1;
   logic [31:0]            calcV2;
   logic [ROB_WIDTH-1:0]   robIdCal;
   logic [31:0]            aluResult;

   logic                   freeFound;
   logic [RS_WIDTH-1:0]    freeIdx;
   logic                   selFound;
   logic [RS_WIDTH-1:0]    selIdx;
   logic                   canOut;
   logic                   aluBcast;
   logic                   selFire;
   logic                   addAccept;

   logic                   addLsbHit1;
   logic                   addLsbHit2;
   logic                   addAluHit1;
   logic                   addAluHit2;
   logic [31:0]            insVal1;
   logic [31:0]            insVal2;
   logic                   insDep1;
   logic                   insDep2;

   assign aluResult = aluCompute(calcOp, calcV1, calcV2);
   assign canOut    = !update || updateReady;
   assign aluBcast  = calcValid && canOut;
   assign selFire   = !flush && selFound && (!calcValid || canOut);
   assign addAccept = !flush && addValid && (count != DEPTH_COUNT) && freeFound;
   assign full      = (count > FULL_LIMIT);

   // Same-cycle bypass for the incoming entry; the LSB bus wins over the ALU bus.
   assign addLsbHit1 = addHasDep1 && lsbUpdate && (addConstrt1 == lsbRobIndex);
   assign addLsbHit2 = addHasDep2 && lsbUpdate && (addConstrt2 == lsbRobIndex);
   assign addAluHit1 = addHasDep1 && aluBcast && (addConstrt1 == robIdCal);
   assign addAluHit2 = addHasDep2 && aluBcast && (addConstrt2 == robIdCal);
   assign insVal1 = addLsbHit1 ? lsbUpdateVal : (addAluHit1 ? aluResult : addVal1);
   assign insVal2 = addLsbHit2 ? lsbUpdateVal : (addAluHit2 ? aluResult : addVal2);
   assign insDep1 = addHasDep1 && !addLsbHit1 && !addAluHit1;
   assign insDep2 = addHasDep2 && !addLsbHit2 && !addAluHit2;

   // Lowest-index free slot and lowest-index ready entry (scan downward so the lowest wins).
   always_comb begin
      freeFound = 1'b0;
      freeIdx   = {RS_WIDTH{1'b0}};
      selFound  = 1'b0;
      selIdx    = {RS_WIDTH{1'b0}};
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!entryValid[i]) begin
            freeFound = 1'b1;
            freeIdx   = RS_WIDTH'(i);
         end else if (!entryDep1[i] && !entryDep2[i]) begin
            selFound = 1'b1;
            selIdx   = RS_WIDTH'(i);
         end else begin
            selFound = selFound;
         end
      end
   end

   // Entry storage: wakeup from both buses, retire on selection, insert into the free slot.
   always_ff @(posedge clockIn or posedge resetIn) begin
      if (resetIn) begin
         entryValid <= {DEPTH{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            entryOp[i]    <= {RS_OP_WIDTH{1'b0}};
            entryTag[i]   <= {ROB_WIDTH{1'b0}};
            entryVal1[i]  <= 32'd0;
            entryVal2[i]  <= 32'd0;
            entryDep1[i]  <= 1'b0;
            entryDep2[i]  <= 1'b0;
            entryCons1[i] <= {ROB_WIDTH{1'b0}};
            entryCons2[i] <= {ROB_WIDTH{1'b0}};
         end
      end else if (flush) begin
         entryValid <= {DEPTH{1'b0}};
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (entryValid[i] && entryDep1[i]) begin
               if (lsbUpdate && (entryCons1[i] == lsbRobIndex)) begin
                  entryVal1[i] <= lsbUpdateVal;
                  entryDep1[i] <= 1'b0;
               end else if (aluBcast && (entryCons1[i] == robIdCal)) begin
                  entryVal1[i] <= aluResult;
                  entryDep1[i] <= 1'b0;
               end
            end
            if (entryValid[i] && entryDep2[i]) begin
               if (lsbUpdate && (entryCons2[i] == lsbRobIndex)) begin
                  entryVal2[i] <= lsbUpdateVal;
                  entryDep2[i] <= 1'b0;
               end else if (aluBcast && (entryCons2[i] == robIdCal)) begin
                  entryVal2[i] <= aluResult;
                  entryDep2[i] <= 1'b0;
               end
            end
         end
         if (selFire) begin
            entryValid[selIdx] <= 1'b0;
         end
         if (addAccept) begin
            entryValid[freeIdx] <= 1'b1;
            entryOp[freeIdx]    <= addOp;
            entryTag[freeIdx]   <= addRobIndex;
            entryVal1[freeIdx]  <= insVal1;
            entryVal2[freeIdx]  <= insVal2;
            entryDep1[freeIdx]  <= insDep1;
            entryDep2[freeIdx]  <= insDep2;
            entryCons1[freeIdx] <= addConstrt1;
            entryCons2[freeIdx] <= addConstrt2;
         end
      end
   end

   // Occupancy count tracks accepted inserts minus selections.
   always_ff @(posedge clockIn or posedge resetIn) begin
      if (resetIn) begin
         count <= {(RS_WIDTH + 1){1'b0}};
      end else if (flush) begin
         count <= {(RS_WIDTH + 1){1'b0}};
      end else begin
         count <= count + {{RS_WIDTH{1'b0}}, addAccept} - {{RS_WIDTH{1'b0}}, selFire};
      end
   end

   // Calc stage holds while the output register is stalled.
   always_ff @(posedge clockIn or posedge resetIn) begin
      if (resetIn) begin
         calcValid <= 1'b0;
         calcOp    <= {RS_OP_WIDTH{1'b0}};
         calcV1    <= 32'd0;
         calcV2    <= 32'd0;
         robIdCal  <= {ROB_WIDTH{1'b0}};
      end else if (flush) begin
         calcValid <= 1'b0;
      end else if (selFire) begin
         calcValid <= 1'b1;
         calcOp    <= entryOp[selIdx];
         calcV1    <= entryVal1[selIdx];
         calcV2    <= entryVal2[selIdx];
         robIdCal  <= entryTag[selIdx];
      end else if (canOut) begin
         calcValid <= 1'b0;
      end
   end

   // Output register: loads when empty or accepted, otherwise holds its result.
   always_ff @(posedge clockIn or posedge resetIn) begin
      if (resetIn) begin
         update      <= 1'b0;
         updateRobId <= {ROB_WIDTH{1'b0}};
         updateVal   <= 32'd0;
      end else if (flush) begin
         update <= 1'b0;
      end else if (aluBcast) begin
         update      <= 1'b1;
         updateRobId <= robIdCal;
         updateVal   <= aluResult;
      end else if (updateReady) begin
         update <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed self-checking bench for alu_reservation_station with hand-computed expectations.
module tb_alu_reservation_station;

   logic        clockIn = 1'b0;
   logic        resetIn;
   logic        flush;
   logic        addValid;
   logic [3:0]  addOp;
   logic [3:0]  addRobIndex;
   logic [31:0] addVal1;
   logic [31:0] addVal2;
   logic        addHasDep1;
   logic        addHasDep2;
   logic [3:0]  addConstrt1;
   logic [3:0]  addConstrt2;
   logic        full;
   logic        lsbUpdate;
   logic [3:0]  lsbRobIndex;
   logic [31:0] lsbUpdateVal;
   logic        update;
   logic        updateReady;
   logic [3:0]  updateRobId;
   logic [31:0] updateVal;

   int errors = 0;
   int checks = 0;

   alu_reservation_station dut (
      .clockIn(clockIn), .resetIn(resetIn), .flush(flush),
      .addValid(addValid), .addOp(addOp), .addRobIndex(addRobIndex),
      .addVal1(addVal1), .addVal2(addVal2),
      .addHasDep1(addHasDep1), .addHasDep2(addHasDep2),
      .addConstrt1(addConstrt1), .addConstrt2(addConstrt2),
      .full(full), .lsbUpdate(lsbUpdate), .lsbRobIndex(lsbRobIndex),
      .lsbUpdateVal(lsbUpdateVal), .update(update), .updateReady(updateReady),
      .updateRobId(updateRobId), .updateVal(updateVal)
   );

   always #5 clockIn = ~clockIn;

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clockIn);
      #1;
   endtask

   task automatic clearInputs();
      flush = 1'b0; addValid = 1'b0; addOp = 4'd0; addRobIndex = 4'd0;
      addVal1 = 32'd0; addVal2 = 32'd0; addHasDep1 = 1'b0; addHasDep2 = 1'b0;
      addConstrt1 = 4'd0; addConstrt2 = 4'd0;
      lsbUpdate = 1'b0; lsbRobIndex = 4'd0; lsbUpdateVal = 32'd0;
   endtask

   task automatic addEntry(input logic [3:0] op, input logic [3:0] tag, input logic [31:0] v1,
                           input logic [31:0] v2, input logic d1, input logic [3:0] c1);
      addValid = 1'b1; addOp = op; addRobIndex = tag; addVal1 = v1; addVal2 = v2;
      addHasDep1 = d1; addConstrt1 = c1; addHasDep2 = 1'b0; addConstrt2 = 4'd0;
   endtask

   task automatic test_reset();
      resetIn = 1'b1; updateReady = 1'b1; clearInputs();
      step(); step();
      checks++; if (update !== 1'b0) begin errors++; $display("FAIL reset_update: got %0b expected 0", update); end
      checks++; if (updateRobId !== 4'd0) begin errors++; $display("FAIL reset_tag: got %0d expected 0", updateRobId); end
      checks++; if (updateVal !== 32'd0) begin errors++; $display("FAIL reset_val: got %0h expected 0", updateVal); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b expected 0", full); end
      checks++; if (dut.count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", dut.count); end
      resetIn = 1'b0;
      step();
   endtask

   task automatic test_add_basic();
      addEntry(4'd0, 4'd3, 32'd5, 32'd7, 1'b0, 4'd0);
      step(); clearInputs();
      checks++; if (update !== 1'b0) begin errors++; $display("FAIL basic_early1: got %0b expected 0", update); end
      step();
      checks++; if (update !== 1'b0) begin errors++; $display("FAIL basic_early2: got %0b expected 0", update); end
      step();
      checks++; if (update !== 1'b1) begin errors++; $display("FAIL basic_update: got %0b expected 1", update); end
      checks++; if (updateRobId !== 4'd3) begin errors++; $display("FAIL basic_tag: got %0d expected 3", updateRobId); end
      checks++; if (updateVal !== 32'd12) begin errors++; $display("FAIL basic_val: got %0d expected 12", updateVal); end
      step();
      checks++; if (update !== 1'b0) begin errors++; $display("FAIL basic_drop: got %0b expected 0", update); end
   endtask

   task automatic test_lsb_wakeup();
      addEntry(4'd1, 4'd4, 32'd0, 32'd1, 1'b1, 4'd9);
      step(); clearInputs(); step(); step();
      checks++; if (update !== 1'b0) begin errors++; $display("FAIL lsb_blocked: got %0b expected 0", update); end
      lsbUpdate = 1'b1; lsbRobIndex = 4'd9; lsbUpdateVal = 32'd10;
      step(); clearInputs(); step();
      checks++; if (update !== 1'b0) begin errors++; $display("FAIL lsb_early: got %0b expected 0", update); end
      step();
      checks++; if (update !== 1'b1 || updateRobId !== 4'd4) begin errors++; $display("FAIL lsb_tag: got %0b/%0d expected 1/4", update, updateRobId); end
      checks++; if (updateVal !== 32'd9) begin errors++; $display("FAIL lsb_val: got %0d expected 9", updateVal); end
      step();
   endtask

   task automatic test_bypass();
      // Stored W and incoming Y both wait on tag 6 while ALU (3) and LSB (50) broadcast tag 6.
      addEntry(4'd0, 4'd8, 32'd0, 32'd1000, 1'b1, 4'd6);
      step();
      addEntry(4'd0, 4'd6, 32'd1, 32'd2, 1'b0, 4'd0);
      step(); clearInputs(); step();
      addEntry(4'd0, 4'd7, 32'd0, 32'd0, 1'b1, 4'd6);
      lsbUpdate = 1'b1; lsbRobIndex = 4'd6; lsbUpdateVal = 32'd50;
      step(); clearInputs();
      checks++; if (update !== 1'b1 || updateRobId !== 4'd6 || updateVal !== 32'd3) begin errors++; $display("FAIL prio_x: got %0b/%0d/%0d expected 1/6/3", update, updateRobId, updateVal); end
      step(); step();
      checks++; if (update !== 1'b1 || updateRobId !== 4'd8 || updateVal !== 32'd1050) begin errors++; $display("FAIL prio_stored: got %0b/%0d/%0d expected 1/8/1050", update, updateRobId, updateVal); end
      step();
      checks++; if (update !== 1'b1 || updateRobId !== 4'd7 || updateVal !== 32'd50) begin errors++; $display("FAIL prio_insert: got %0b/%0d/%0d expected 1/7/50", update, updateRobId, updateVal); end
      step();
      // Insertion bypass from the ALU bus alone.
      addEntry(4'd0, 4'd3, 32'd5, 32'd7, 1'b0, 4'd0);
      step(); clearInputs(); step();
      addEntry(4'd0, 4'd5, 32'd0, 32'd100, 1'b1, 4'd3);
      step(); clearInputs();
      checks++; if (update !== 1'b1 || updateRobId !== 4'd3 || updateVal !== 32'd12) begin errors++; $display("FAIL alubyp_src: got %0b/%0d/%0d expected 1/3/12", update, updateRobId, updateVal); end
      step(); step();
      checks++; if (update !== 1'b1 || updateRobId !== 4'd5 || updateVal !== 32'd112) begin errors++; $display("FAIL alubyp_dst: got %0b/%0d/%0d expected 1/5/112", update, updateRobId, updateVal); end
      step();
      // Stored entry woken by the ALU bus.
      addEntry(4'd0, 4'd12, 32'd0, 32'd1, 1'b1, 4'd11);
      step();
      addEntry(4'd0, 4'd11, 32'd4, 32'd4, 1'b0, 4'd0);
      step(); clearInputs(); step(); step();
      checks++; if (update !== 1'b1 || updateRobId !== 4'd11 || updateVal !== 32'd8) begin errors++; $display("FAIL aluwake_src: got %0b/%0d/%0d expected 1/11/8", update, updateRobId, updateVal); end
      step(); step();
      checks++; if (update !== 1'b1 || updateRobId !== 4'd12 || updateVal !== 32'd9) begin errors++; $display("FAIL aluwake_dst: got %0b/%0d/%0d expected 1/12/9", update, updateRobId, updateVal); end
      step();
   endtask

   task automatic test_ops();
      logic [3:0]  opT  [16];
      logic [31:0] aT   [16];
      logic [31:0] bT   [16];
      logic [31:0] expT [16];
      opT[0]  = 4'd0;  aT[0]  = 32'd5;        bT[0]  = 32'd7;        expT[0]  = 32'd12;
      opT[1]  = 4'd1;  aT[1]  = 32'd3;        bT[1]  = 32'd5;        expT[1]  = 32'hFFFFFFFE;
      opT[2]  = 4'd2;  aT[2]  = 32'h0000F0F0; bT[2]  = 32'h0000FF00; expT[2]  = 32'h00000FF0;
      opT[3]  = 4'd3;  aT[3]  = 32'h000000F0; bT[3]  = 32'h0000000F; expT[3]  = 32'h000000FF;
      opT[4]  = 4'd4;  aT[4]  = 32'h0000F0F0; bT[4]  = 32'h0000FF00; expT[4]  = 32'h0000F000;
      opT[5]  = 4'd5;  aT[5]  = 32'd1;        bT[5]  = 32'h00000024; expT[5]  = 32'h00000010;
      opT[6]  = 4'd6;  aT[6]  = 32'h80000000; bT[6]  = 32'h00000021; expT[6]  = 32'h40000000;
      opT[7]  = 4'd7;  aT[7]  = 32'h80000000; bT[7]  = 32'h00000021; expT[7]  = 32'hC0000000;
      opT[8]  = 4'd8;  aT[8]  = 32'd5;        bT[8]  = 32'd5;        expT[8]  = 32'd1;
      opT[9]  = 4'd9;  aT[9]  = 32'd5;        bT[9]  = 32'd6;        expT[9]  = 32'd1;
      opT[10] = 4'd10; aT[10] = 32'hFFFFFFFF; bT[10] = 32'd1;        expT[10] = 32'd1;
      opT[11] = 4'd11; aT[11] = 32'hFFFFFFFF; bT[11] = 32'd1;        expT[11] = 32'd0;
      opT[12] = 4'd12; aT[12] = 32'd3;        bT[12] = 32'd4;        expT[12] = 32'd0;
      opT[13] = 4'd15; aT[13] = 32'd3;        bT[13] = 32'd4;        expT[13] = 32'd0;
      opT[14] = 4'd10; aT[14] = 32'd1;        bT[14] = 32'hFFFFFFFF; expT[14] = 32'd0;
      opT[15] = 4'd7;  aT[15] = 32'h40000000; bT[15] = 32'd1;        expT[15] = 32'h20000000;
      for (int c = 0; c < 18; c++) begin
         if (c < 16) addEntry(opT[c], 4'(c), aT[c], bT[c], 1'b0, 4'd0);
         else clearInputs();
         step();
         if (c >= 2) begin
            checks++;
            if (update !== 1'b1 || updateRobId !== 4'(c - 2) || updateVal !== expT[c - 2]) begin
               errors++;
               $display("FAIL op_%0d: got %0b/%0d/%0h expected 1/%0d/%0h", c - 2, update, updateRobId, updateVal, c - 2, expT[c - 2]);
            end
         end
      end
      step();
      checks++; if (update !== 1'b0) begin errors++; $display("FAIL ops_drain: got %0b expected 0", update); end
   endtask

   task automatic test_full();
      for (int i = 0; i < 16; i++) begin
         addEntry(4'd0, 4'(i), 32'd0, 32'(i), 1'b1, 4'd15);
         step();
         if (i == 13) begin
            checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_at14: got %0b expected 0", full); end
         end
         if (i == 14) begin
            checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_at15: got %0b expected 1", full); end
         end
      end
      checks++; if (dut.count !== 5'd16 || full !== 1'b1) begin errors++; $display("FAIL full_at16: got %0d/%0b expected 16/1", dut.count, full); end
      addEntry(4'd0, 4'd0, 32'd0, 32'd777, 1'b0, 4'd0);
      step(); clearInputs();
      checks++; if (dut.count !== 5'd16) begin errors++; $display("FAIL full_extra: got %0d expected 16", dut.count); end
      lsbUpdate = 1'b1; lsbRobIndex = 4'd15; lsbUpdateVal = 32'd100;
      step(); clearInputs(); step();
      checks++; if (update !== 1'b0) begin errors++; $display("FAIL full_early: got %0b expected 0", update); end
      for (int k = 0; k < 16; k++) begin
         step();
         checks++;
         if (update !== 1'b1 || updateRobId !== 4'(k) || updateVal !== 32'(100 + k)) begin
            errors++;
            $display("FAIL full_drain_%0d: got %0b/%0d/%0d expected 1/%0d/%0d", k, update, updateRobId, updateVal, k, 100 + k);
         end
      end
      step();
      checks++; if (update !== 1'b0 || dut.count !== 5'd0) begin errors++; $display("FAIL full_empty: got %0b/%0d expected 0/0", update, dut.count); end
   endtask

   task automatic test_back_to_back();
      updateReady = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         addEntry(4'd0, 4'(i), 32'd0, 32'(i), 1'b1, 4'd14);
         step();
      end
      clearInputs();
      lsbUpdate = 1'b1; lsbRobIndex = 4'd14; lsbUpdateVal = 32'd10;
      step(); clearInputs();
      checks++; if (dut.count !== 5'd3) begin errors++; $display("FAIL bp_count3: got %0d expected 3", dut.count); end
      step(); step();
      for (int h = 0; h < 4; h++) begin
         checks++;
         if (update !== 1'b1 || updateRobId !== 4'd1 || updateVal !== 32'd11 || dut.count !== 5'd1) begin
            errors++;
            $display("FAIL bp_hold_%0d: got %0b/%0d/%0d/%0d expected 1/1/11/1", h, update, updateRobId, updateVal, dut.count);
         end
         if (h < 3) step();
      end
      updateReady = 1'b1;
      step();
      checks++; if (update !== 1'b1 || updateRobId !== 4'd2 || updateVal !== 32'd12) begin errors++; $display("FAIL bp_second: got %0b/%0d/%0d expected 1/2/12", update, updateRobId, updateVal); end
      step();
      checks++; if (update !== 1'b1 || updateRobId !== 4'd3 || updateVal !== 32'd13) begin errors++; $display("FAIL bp_third: got %0b/%0d/%0d expected 1/3/13", update, updateRobId, updateVal); end
      step();
      checks++; if (update !== 1'b0 || dut.count !== 5'd0) begin errors++; $display("FAIL bp_empty: got %0b/%0d expected 0/0", update, dut.count); end
   endtask

   task automatic test_flush();
      updateReady = 1'b0;
      addEntry(4'd0, 4'd1, 32'd1, 32'd1, 1'b0, 4'd0);
      step();
      addEntry(4'd0, 4'd2, 32'd2, 32'd2, 1'b0, 4'd0);
      step();
      for (int i = 5; i <= 9; i++) begin
         addEntry(4'd0, 4'(i), 32'd0, 32'd1, 1'b1, 4'd13);
         step();
      end
      clearInputs();
      checks++; if (dut.count !== 5'd5) begin errors++; $display("FAIL flush_pre_count: got %0d expected 5", dut.count); end
      checks++; if (update !== 1'b1 || updateRobId !== 4'd1 || updateVal !== 32'd2) begin errors++; $display("FAIL flush_pre_update: got %0b/%0d/%0d expected 1/1/2", update, updateRobId, updateVal); end
      flush = 1'b1;
      addEntry(4'd0, 4'd10, 32'd7, 32'd7, 1'b0, 4'd0);
      lsbUpdate = 1'b1; lsbRobIndex = 4'd13; lsbUpdateVal = 32'd0;
      step(); clearInputs();
      checks++; if (dut.count !== 5'd0 || update !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL flush_clear: got %0d/%0b/%0b expected 0/0/0", dut.count, update, full); end
      updateReady = 1'b1;
      step(); step(); step();
      checks++; if (update !== 1'b0 || dut.count !== 5'd0) begin errors++; $display("FAIL flush_quiet: got %0b/%0d expected 0/0", update, dut.count); end
      addEntry(4'd0, 4'd10, 32'd2, 32'd3, 1'b0, 4'd0);
      step(); clearInputs(); step(); step();
      checks++; if (update !== 1'b1 || updateRobId !== 4'd10 || updateVal !== 32'd5) begin errors++; $display("FAIL flush_resume: got %0b/%0d/%0d expected 1/10/5", update, updateRobId, updateVal); end
      step();
   endtask

   task automatic test_async_reset();
      updateReady = 1'b0;
      addEntry(4'd0, 4'd6, 32'd20, 32'd22, 1'b0, 4'd0);
      step(); clearInputs(); step(); step();
      checks++; if (update !== 1'b1 || updateVal !== 32'd42) begin errors++; $display("FAIL arst_pre: got %0b/%0d expected 1/42", update, updateVal); end
      #2 resetIn = 1'b1;
      #1;
      checks++; if (update !== 1'b0 || updateRobId !== 4'd0 || updateVal !== 32'd0) begin errors++; $display("FAIL arst_async: got %0b/%0d/%0d expected 0/0/0", update, updateRobId, updateVal); end
      checks++; if (full !== 1'b0 || dut.count !== 5'd0) begin errors++; $display("FAIL arst_count: got %0b/%0d expected 0/0", full, dut.count); end
      step();
      resetIn = 1'b0; updateReady = 1'b1;
      addEntry(4'd0, 4'd2, 32'd1, 32'd1, 1'b0, 4'd0);
      step(); clearInputs(); step(); step();
      checks++; if (update !== 1'b1 || updateRobId !== 4'd2 || updateVal !== 32'd2) begin errors++; $display("FAIL arst_resume: got %0b/%0d/%0d expected 1/2/2", update, updateRobId, updateVal); end
      step();
   endtask

   initial begin
      resetIn = 1'b1;
      updateReady = 1'b1;
      clearInputs();
      test_reset();
      test_add_basic();
      test_lsb_wakeup();
      test_bypass();
      test_ops();
      test_full();
      test_back_to_back();
      test_flush();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
